// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one ALU and a single registered result slot.
// Define ALU_ARB_FIXED_PRIO_EN to use fixed priority to port 0 with a port-1 starvation guard.

package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        AluAdd = 4'd0,
        AluSub = 4'd1,
        AluSll = 4'd2,
        AluLt  = 4'd3,
        AluLtu = 4'd4,
        AluXor = 4'd5,
        AluSrl = 4'd6,
        AluSra = 4'd7,
        AluOr  = 4'd8,
        AluAnd = 4'd9
    } alu_operation_t;

endpackage

module alu
    import alu_arbiter_pkg::*;
(
    input  alu_operation_t op,
    input  logic [31:0]    lhs,
    input  logic [31:0]    rhs,
    output logic [31:0]    result
);

    always_comb begin
        result = '0;
        case (op)
            AluAdd:  result = lhs + rhs;
            AluSub:  result = lhs - rhs;
            AluSll:  result = lhs << rhs[4:0];
            AluSrl:  result = lhs >> rhs[4:0];
            AluSra:  result = $unsigned($signed(lhs) >>> rhs[4:0]);
            AluLt:   result = {31'd0, $signed(lhs) < $signed(rhs)};
            AluLtu:  result = {31'd0, lhs < rhs};
            AluXor:  result = lhs ^ rhs;
            AluOr:   result = lhs | rhs;
            AluAnd:  result = lhs & rhs;
            default: result = '0;
        endcase
    end

endmodule

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,

    input  logic           req_valid_0,
    output logic           req_ready_0,
    input  alu_operation_t req_op_0,
    input  logic [31:0]    req_lhs_0,
    input  logic [31:0]    req_rhs_0,

    input  logic           req_valid_1,
    output logic           req_ready_1,
    input  alu_operation_t req_op_1,
    input  logic [31:0]    req_lhs_1,
    input  logic [31:0]    req_rhs_1,

    output logic           rsp_valid_0,
    input  logic           rsp_ready_0,
    output logic           rsp_valid_1,
    input  logic           rsp_ready_1,
    output logic [31:0]    rsp_result
);

    typedef enum logic {SlotEmpty, SlotFull} slot_state_t;

    slot_state_t    slot_q;
    logic           slot_owner_q;

    logic           grant_valid;
    logic           grant_port;
    logic           slot_free;
    logic           drain;
    logic           accept;

    alu_operation_t alu_op;
    logic [31:0]    alu_lhs;
    logic [31:0]    alu_rhs;
    logic [31:0]    alu_result;

    // Owner draining this cycle frees the slot for a same-cycle refill.
    always_comb begin
        drain     = (slot_q == SlotFull) && (slot_owner_q ? rsp_ready_1 : rsp_ready_0);
        slot_free = (slot_q == SlotEmpty) || drain;
    end

`ifdef ALU_ARB_FIXED_PRIO_EN

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic [3:0] starve_q;
    logic       starve_hit;

    always_comb begin
        starve_hit  = (starve_q == StarveMax);
        grant_valid = req_valid_0 | req_valid_1;
        grant_port  = req_valid_1 & (~req_valid_0 | starve_hit);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else if (req_ready_1) begin
            starve_q <= '0;
        end else if (req_valid_1 && slot_free && !grant_port && starve_q != 4'hf) begin
            starve_q <= starve_q + 4'd1;
        end
    end

`else

    logic last_grant_q;

    // On a tie the port that did not win last time is served.
    always_comb begin
        grant_valid = req_valid_0 | req_valid_1;
        grant_port  = req_valid_1 & (~req_valid_0 | ~last_grant_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= grant_port;
        end
    end

`endif

    always_comb begin
        accept      = grant_valid & slot_free & ~reset;
        req_ready_0 = accept & ~grant_port;
        req_ready_1 = accept & grant_port;
    end

    always_comb begin
        alu_op  = grant_port ? req_op_1  : req_op_0;
        alu_lhs = grant_port ? req_lhs_1 : req_lhs_0;
        alu_rhs = grant_port ? req_rhs_1 : req_rhs_0;
    end

    alu u_alu (
        .op     (alu_op),
        .lhs    (alu_lhs),
        .rhs    (alu_rhs),
        .result (alu_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q       <= SlotEmpty;
            slot_owner_q <= 1'b0;
            rsp_valid_0  <= 1'b0;
            rsp_valid_1  <= 1'b0;
            rsp_result   <= '0;
        end else begin
            case (slot_q)
                SlotEmpty: begin
                    if (accept) begin
                        slot_q       <= SlotFull;
                        slot_owner_q <= grant_port;
                        rsp_valid_0  <= ~grant_port;
                        rsp_valid_1  <= grant_port;
                        rsp_result   <= alu_result;
                    end
                end
                SlotFull: begin
                    if (accept) begin
                        slot_owner_q <= grant_port;
                        rsp_valid_0  <= ~grant_port;
                        rsp_valid_1  <= grant_port;
                        rsp_result   <= alu_result;
                    end else if (drain) begin
                        slot_q      <= SlotEmpty;
                        rsp_valid_0 <= 1'b0;
                        rsp_valid_1 <= 1'b0;
                    end
                end
                default: slot_q <= SlotEmpty;
            endcase
        end
    end

    a_starve_max_legal: assert property (@(posedge clk)
        (STARVE_MAX >= 1) && (STARVE_MAX <= 15));

    a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
        !(req_ready_0 && req_ready_1));

    // Requesters must hold valid until accepted, so valid cannot be a function of ready.
    a_req_hold_0: assert property (@(posedge clk) disable iff (reset)
        req_valid_0 && !req_ready_0 |=> req_valid_0);

    a_req_hold_1: assert property (@(posedge clk) disable iff (reset)
        req_valid_1 && !req_ready_1 |=> req_valid_1);

    a_rsp_stable_0: assert property (@(posedge clk) disable iff (reset)
        rsp_valid_0 && !rsp_ready_0 |=> $stable(rsp_result));

    a_rsp_stable_1: assert property (@(posedge clk) disable iff (reset)
        rsp_valid_1 && !rsp_ready_1 |=> $stable(rsp_result));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: reset, single transfer, arbitration,
// backpressure handoff and mid-operation reset.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           req_valid_0, req_valid_1;
    logic           req_ready_0, req_ready_1;
    alu_operation_t req_op_0, req_op_1;
    logic [31:0]    req_lhs_0, req_rhs_0, req_lhs_1, req_rhs_1;
    logic           rsp_valid_0, rsp_valid_1;
    logic           rsp_ready_0, rsp_ready_1;
    logic [31:0]    rsp_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .STARVE_MAX (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_0 (req_valid_0),
        .req_ready_0 (req_ready_0),
        .req_op_0    (req_op_0),
        .req_lhs_0   (req_lhs_0),
        .req_rhs_0   (req_rhs_0),
        .req_valid_1 (req_valid_1),
        .req_ready_1 (req_ready_1),
        .req_op_1    (req_op_1),
        .req_lhs_1   (req_lhs_1),
        .req_rhs_1   (req_rhs_1),
        .rsp_valid_0 (rsp_valid_0),
        .rsp_ready_0 (rsp_ready_0),
        .rsp_valid_1 (rsp_valid_1),
        .rsp_ready_1 (rsp_ready_1),
        .rsp_result  (rsp_result)
    );

    task automatic idle_inputs();
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        req_op_0 = AluAdd;  req_op_1 = AluAdd;
        req_lhs_0 = '0; req_rhs_0 = '0; req_lhs_1 = '0; req_rhs_1 = '0;
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        reset = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b00) begin
            errors++; $display("FAIL reset_req_ready: got %b want 00", {req_ready_0, req_ready_1});
        end
        checks++;
        if ({rsp_valid_0, rsp_valid_1} !== 2'b00) begin
            errors++; $display("FAIL reset_rsp_valid: got %b want 00", {rsp_valid_0, rsp_valid_1});
        end
        checks++;
        if (rsp_result !== 32'd0) begin
            errors++; $display("FAIL reset_rsp_result: got %0d want 0", rsp_result);
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1} !== 2'b00) begin
            errors++; $display("FAIL reset_idle_after: got %b want 00", {rsp_valid_0, rsp_valid_1});
        end
    endtask

    task automatic test_single_add();
        req_valid_0 = 1'b1; req_op_0 = AluAdd; req_lhs_0 = 32'd5; req_rhs_0 = 32'd7;
        rsp_ready_0 = 1'b1;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b10) begin
            errors++; $display("FAIL single_req_ready: got %b want 10", {req_ready_0, req_ready_1});
        end
        @(negedge clk);
        req_valid_0 = 1'b0;
        #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1} !== 2'b10) begin
            errors++; $display("FAIL single_rsp_valid: got %b want 10", {rsp_valid_0, rsp_valid_1});
        end
        checks++;
        if (rsp_result !== 32'd12) begin
            errors++; $display("FAIL single_rsp_result: got %0d want 12", rsp_result);
        end
        @(negedge clk); #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1} !== 2'b00) begin
            errors++; $display("FAIL single_drain: got %b want 00", {rsp_valid_0, rsp_valid_1});
        end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_rdy;
        logic [1:0]  exp_rv;
        logic [31:0] exp_res;
        do_reset();
        req_valid_0 = 1'b1; req_op_0 = AluSub; req_lhs_0 = 32'd10; req_rhs_0 = 32'd3;
        req_valid_1 = 1'b1; req_op_1 = AluSll; req_lhs_1 = 32'd1;  req_rhs_1 = 32'd4;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
            checks++;
            if ({req_ready_0, req_ready_1} !== exp_rdy) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i,
                                   {req_ready_0, req_ready_1}, exp_rdy);
            end
            if (i > 0) begin
                exp_rv  = (i % 2 == 1) ? 2'b10 : 2'b01;
                exp_res = (i % 2 == 1) ? 32'd7 : 32'd16;
                checks++;
                if ({rsp_valid_0, rsp_valid_1} !== exp_rv || rsp_result !== exp_res) begin
                    errors++; $display("FAIL rr_rsp[%0d]: got %b/%0d want %b/%0d", i,
                                       {rsp_valid_0, rsp_valid_1}, rsp_result, exp_rv, exp_res);
                end
            end
            @(negedge clk);
        end
        // Port 1 won the last tie; port 0 is still waiting.
        req_valid_1 = 1'b0;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b10) begin
            errors++; $display("FAIL rr_tail_grant: got %b want 10", {req_ready_0, req_ready_1});
        end
        checks++;
        if ({rsp_valid_0, rsp_valid_1} !== 2'b01 || rsp_result !== 32'd16) begin
            errors++; $display("FAIL rr_tail_rsp1: got %b/%0d want 01/16",
                               {rsp_valid_0, rsp_valid_1}, rsp_result);
        end
        @(negedge clk);
        req_valid_0 = 1'b0;
        #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1} !== 2'b10 || rsp_result !== 32'd7) begin
            errors++; $display("FAIL rr_tail_rsp0: got %b/%0d want 10/7",
                               {rsp_valid_0, rsp_valid_1}, rsp_result);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_fixed_prio();
        logic [1:0]  exp_rdy;
        logic [1:0]  exp_rv;
        logic [31:0] exp_res;
        logic        prev_p1;
        do_reset();
        req_valid_0 = 1'b1; req_op_0 = AluAdd; req_lhs_0 = 32'd2;  req_rhs_0 = 32'd3;
        req_valid_1 = 1'b1; req_op_1 = AluSub; req_lhs_1 = 32'd20; req_rhs_1 = 32'd4;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        prev_p1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_rdy = (i % 5 == 4) ? 2'b01 : 2'b10;
            checks++;
            if ({req_ready_0, req_ready_1} !== exp_rdy) begin
                errors++; $display("FAIL fp_grant[%0d]: got %b want %b", i,
                                   {req_ready_0, req_ready_1}, exp_rdy);
            end
            if (i > 0) begin
                exp_rv  = prev_p1 ? 2'b01 : 2'b10;
                exp_res = prev_p1 ? 32'd16 : 32'd5;
                checks++;
                if ({rsp_valid_0, rsp_valid_1} !== exp_rv || rsp_result !== exp_res) begin
                    errors++; $display("FAIL fp_rsp[%0d]: got %b/%0d want %b/%0d", i,
                                       {rsp_valid_0, rsp_valid_1}, rsp_result, exp_rv, exp_res);
                end
            end
            prev_p1 = (i % 5 == 4);
            @(negedge clk);
        end
        req_valid_1 = 1'b0;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b10) begin
            errors++; $display("FAIL fp_tail_grant: got %b want 10", {req_ready_0, req_ready_1});
        end
        @(negedge clk);
        req_valid_0 = 1'b0;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_backpressure();
        req_valid_0 = 1'b1; req_op_0 = AluAdd; req_lhs_0 = 32'd1; req_rhs_0 = 32'd1;
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b10) begin
            errors++; $display("FAIL bp_accept: got %b want 10", {req_ready_0, req_ready_1});
        end
        @(negedge clk);
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b1; req_op_1 = AluLtu; req_lhs_1 = 32'd1; req_rhs_1 = 32'd2;
        rsp_ready_1 = 1'b1;   // non-owner ready must not free the slot
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({rsp_valid_0, rsp_valid_1} !== 2'b10 || rsp_result !== 32'd2) begin
                errors++; $display("FAIL bp_hold[%0d]: got %b/%0d want 10/2", i,
                                   {rsp_valid_0, rsp_valid_1}, rsp_result);
            end
            checks++;
            if ({req_ready_0, req_ready_1} !== 2'b00) begin
                errors++; $display("FAIL bp_stall_ready[%0d]: got %b want 00", i,
                                   {req_ready_0, req_ready_1});
            end
            @(negedge clk);
        end
        rsp_ready_0 = 1'b1;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b01) begin
            errors++; $display("FAIL bp_handoff: got %b want 01", {req_ready_0, req_ready_1});
        end
        @(negedge clk);
        req_valid_1 = 1'b0; rsp_ready_0 = 1'b0;
        #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1} !== 2'b01 || rsp_result !== 32'd1) begin
            errors++; $display("FAIL bp_handoff_rsp: got %b/%0d want 01/1",
                               {rsp_valid_0, rsp_valid_1}, rsp_result);
        end
        @(negedge clk); #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1} !== 2'b00) begin
            errors++; $display("FAIL bp_drain: got %b want 00", {rsp_valid_0, rsp_valid_1});
        end
        idle_inputs();
    endtask

    task automatic test_reset_midop();
        req_valid_1 = 1'b1; req_op_1 = AluAdd; req_lhs_1 = 32'd3; req_rhs_1 = 32'd4;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b01) begin
            errors++; $display("FAIL midop_accept: got %b want 01", {req_ready_0, req_ready_1});
        end
        @(negedge clk);
        req_valid_1 = 1'b0;
        #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1} !== 2'b01 || rsp_result !== 32'd7) begin
            errors++; $display("FAIL midop_full: got %b/%0d want 01/7",
                               {rsp_valid_0, rsp_valid_1}, rsp_result);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1} !== 2'b00 || rsp_result !== 32'd0) begin
            errors++; $display("FAIL midop_async_clear: got %b/%0d want 00/0",
                               {rsp_valid_0, rsp_valid_1}, rsp_result);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1} !== 2'b00) begin
            errors++; $display("FAIL midop_no_resp: got %b want 00", {rsp_valid_0, rsp_valid_1});
        end
        req_valid_0 = 1'b1; req_op_0 = AluAdd; req_lhs_0 = 32'd2; req_rhs_0 = 32'd2;
        req_valid_1 = 1'b1; req_op_1 = AluSub; req_lhs_1 = 32'd9; req_rhs_1 = 32'd1;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b10) begin
            errors++; $display("FAIL midop_first_tie: got %b want 10", {req_ready_0, req_ready_1});
        end
        @(negedge clk);
        req_valid_0 = 1'b0;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b01) begin
            errors++; $display("FAIL midop_p1_grant: got %b want 01", {req_ready_0, req_ready_1});
        end
        checks++;
        if ({rsp_valid_0, rsp_valid_1} !== 2'b10 || rsp_result !== 32'd4) begin
            errors++; $display("FAIL midop_rsp0: got %b/%0d want 10/4",
                               {rsp_valid_0, rsp_valid_1}, rsp_result);
        end
        @(negedge clk);
        req_valid_1 = 1'b0;
        #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1} !== 2'b01 || rsp_result !== 32'd8) begin
            errors++; $display("FAIL midop_rsp1: got %b/%0d want 01/8",
                               {rsp_valid_0, rsp_valid_1}, rsp_result);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_add();
`ifdef ALU_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
`endif
        test_backpressure();
        test_reset_midop();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
